spi_slave_rx: RTL and testbench

//  Receiving end of the DAC-style SPI link (sclk, sdi, load) driven by spi_master on the control board.

---
 rtl/spi_slave_rx_pkg.sv | 14 +
 rtl/spi_slave_rx_sync_edge_det.sv | 32 +++
 rtl/spi_slave_rx.sv | 172 +++++++++++++++++
 tb/tb_spi_slave_rx.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/spi_slave_rx_pkg.sv
// Shared types and constants for the SPI slave receiver.
// Holds the FSM state encoding and the default DAC word length.
package spi_slave_rx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        OVER  = 2'd2
    } rx_state_t;

    // Word length shared with the spi_master instances on the control board.
    localparam int DAC_W_LENGTH = 10;

endpackage

// File: rtl/spi_slave_rx_sync_edge_det.sv
// Multi-flop synchroniser with one extra flop for edge detection.
// Ports: clk, rst (async high), d in; q synced level, q_prev, rise/fall pulses.
module sync_edge_det #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic q_prev,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sff;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sff    <= {SYNC_STAGES{RESET_VAL}};
            q_prev <= RESET_VAL;
        end else begin
            sff    <= {sff[SYNC_STAGES-2:0], d};
            q_prev <= sff[SYNC_STAGES-1];
        end
    end

    assign q    = sff[SYNC_STAGES-1];
    assign rise = q & ~q_prev;
    assign fall = ~q & q_prev;

endmodule

// File: rtl/spi_slave_rx.sv
// DAC-style SPI receiver: oversamples sclk/sdi/load on clk, deserialises
// one word per load pulse and flags short, long or timed-out frames.
// Ports: clk, rst (async high), sclk_in, sdi_in, load_in (async pins);
// word_out, valid_out, frame_err_out (pulses), frame_cnt_out (good frames).
module spi_slave_rx
    import spi_slave_rx_pkg::*;
#(
    parameter int W_LENGTH    = DAC_W_LENGTH,
    parameter bit INV_CLK     = 1'b1,
    parameter bit INV_DATA    = 1'b1,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 4095
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sclk_in,
    input  logic                sdi_in,
    input  logic                load_in,
    output logic [W_LENGTH-1:0] word_out,
    output logic                valid_out,
    output logic                frame_err_out,
    output logic [15:0]         frame_cnt_out
);

    localparam int CW = $clog2(W_LENGTH + 2);
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] W_C  = CW'(W_LENGTH);
    localparam logic [CW-1:0] WP1  = CW'(W_LENGTH + 1);
    localparam logic [TW-1:0] TO_C = TW'(TIMEOUT);

    logic sclk_q, sclk_prev, sclk_rise, sclk_fall;
    logic load_q, load_prev, load_rise, load_fall;
    logic sdi_q, sdi_prev, sdi_rise, sdi_fall;

    sync_edge_det #(
        .SYNC_STAGES(SYNC_STAGES),
        .RESET_VAL  (INV_CLK)
    ) u_sclk (
        .clk   (clk),
        .rst   (rst),
        .d     (sclk_in),
        .q     (sclk_q),
        .q_prev(sclk_prev),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    sync_edge_det #(
        .SYNC_STAGES(SYNC_STAGES),
        .RESET_VAL  (1'b0)
    ) u_load (
        .clk   (clk),
        .rst   (rst),
        .d     (load_in),
        .q     (load_q),
        .q_prev(load_prev),
        .rise  (load_rise),
        .fall  (load_fall)
    );

    sync_edge_det #(
        .SYNC_STAGES(SYNC_STAGES),
        .RESET_VAL  (1'b0)
    ) u_sdi (
        .clk   (clk),
        .rst   (rst),
        .d     (sdi_in),
        .q     (sdi_q),
        .q_prev(sdi_prev),
        .rise  (sdi_rise),
        .fall  (sdi_fall)
    );

    logic unused_edges;
    assign unused_edges = ^{sclk_q, sclk_prev, load_prev, load_fall,
                            sdi_prev, sdi_rise, sdi_fall};

    rx_state_t               state, state_nxt;
    logic [CW-1:0]           bit_cnt, cnt_nxt;
    logic [W_LENGTH-1:0]     shreg, sh_nxt;
    logic [W_LENGTH:0]       sh_ext;
    logic [TW-1:0]           idle_cnt;
    logic                    sample_edge, smp, timeout_hit;
    logic                    frame_ok, frame_bad;

    assign sample_edge = INV_CLK ? sclk_fall : sclk_rise;
    // While load is high only the load-edge cycle itself may still shift.
    assign smp = sample_edge & ~(load_q & ~load_rise);

    // Shift and count first, so a coincident load sees the final bit.
    always_comb begin
        cnt_nxt = bit_cnt;
        sh_nxt  = shreg;
        sh_ext  = {shreg, sdi_q ^ INV_DATA};
        if (smp) begin
            sh_nxt = sh_ext[W_LENGTH-1:0];
            if (bit_cnt != WP1)
                cnt_nxt = bit_cnt + CW'(1);
        end
    end

    assign timeout_hit = (TIMEOUT != 0) && (state != IDLE)
                         && !smp && (idle_cnt == TO_C);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (load_rise || timeout_hit) begin
            state_nxt = IDLE;
        end else begin
            unique case (1'b1)
                (cnt_nxt == '0): state_nxt = IDLE;
                (cnt_nxt == WP1): state_nxt = OVER;
                default: state_nxt = SHIFT;
            endcase
        end
    end

    always_comb begin
        frame_ok  = 1'b0;
        frame_bad = 1'b0;
        if (load_rise) begin
            if (cnt_nxt == W_C)
                frame_ok = 1'b1;
            else if (cnt_nxt != '0)
                frame_bad = 1'b1;
        end else if (timeout_hit) begin
            frame_bad = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt  <= '0;
            shreg    <= '0;
            idle_cnt <= '0;
        end else begin
            shreg <= sh_nxt;
            if (load_rise || timeout_hit)
                bit_cnt <= '0;
            else
                bit_cnt <= cnt_nxt;
            if (TIMEOUT == 0 || smp || state_nxt == IDLE)
                idle_cnt <= '0;
            else
                idle_cnt <= idle_cnt + TW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_out      <= '0;
            valid_out     <= 1'b0;
            frame_err_out <= 1'b0;
            frame_cnt_out <= '0;
        end else begin
            valid_out     <= frame_ok;
            frame_err_out <= frame_bad;
            if (frame_ok) begin
                word_out      <= sh_nxt;
                frame_cnt_out <= frame_cnt_out + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_spi_slave_rx.sv
// Directed bench for spi_slave_rx with bit-banged SPI frames.
// Ports: none; drives clk/rst and pins, checks outputs against constants.
module tb_spi_slave_rx;

    localparam int T = 4095;

    logic       clk = 1'b0;
    logic       rst;
    logic       sclk_in, sdi_in, load_in;
    logic [9:0] word_out;
    logic       valid_out, frame_err_out;
    logic [15:0] frame_cnt_out;

    int n_chk  = 0;
    int n_pass = 0;
    int v_cnt  = 0;
    int e_cnt  = 0;
    int ovl    = 0;

    always #5 clk = ~clk;

    spi_slave_rx dut (
        .clk          (clk),
        .rst          (rst),
        .sclk_in      (sclk_in),
        .sdi_in       (sdi_in),
        .load_in      (load_in),
        .word_out     (word_out),
        .valid_out    (valid_out),
        .frame_err_out(frame_err_out),
        .frame_cnt_out(frame_cnt_out)
    );

    always @(negedge clk) begin
        if (valid_out)
            v_cnt++;
        if (frame_err_out)
            e_cnt++;
        if (valid_out && frame_err_out)
            ovl++;
    end

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // MSB first, wire data inverted, sample on sclk falling edge.
    task automatic send_bits(input logic [31:0] v, input int n,
                             input bit simul, input bit do_load);
        for (int i = n - 1; i >= 0; i--) begin
            sdi_in = ~v[i];
            tick(7);
            if (simul && i == 0) begin
                sclk_in = 1'b0;
                load_in = 1'b1;
                tick(7);
                sclk_in = 1'b1;
                tick(4);
                load_in = 1'b0;
                tick(3);
            end else begin
                sclk_in = 1'b0;
                tick(7);
                sclk_in = 1'b1;
            end
        end
        if (do_load && !simul) begin
            tick(7);
            load_in = 1'b1;
            tick(4);
            load_in = 1'b0;
        end
        tick(20);
    endtask

    initial begin
        int v0, e0, waited, tot;
        rst     = 1'b1;
        sclk_in = 1'b1;
        sdi_in  = 1'b0;
        load_in = 1'b0;
        tick(3);
        check("rst_word",  32'(word_out), 32'h0);
        check("rst_valid", 32'(valid_out), 32'h0);
        check("rst_err",   32'(frame_err_out), 32'h0);
        check("rst_cnt",   32'(frame_cnt_out), 32'h0);
        rst = 1'b0;
        tick(5);

        v0 = v_cnt; e0 = e_cnt;
        send_bits(32'h2A5, 10, 1'b0, 1'b1);
        check("f1_valid", 32'(v_cnt - v0), 32'd1);
        check("f1_err",   32'(e_cnt - e0), 32'd0);
        check("f1_word",  32'(word_out), 32'h2A5);
        check("f1_cnt",   32'(frame_cnt_out), 32'd1);

        v0 = v_cnt; e0 = e_cnt;
        send_bits(32'h1AB, 9, 1'b0, 1'b1);
        check("short_err",   32'(e_cnt - e0), 32'd1);
        check("short_valid", 32'(v_cnt - v0), 32'd0);
        check("short_word",  32'(word_out), 32'h2A5);
        check("short_cnt",   32'(frame_cnt_out), 32'd1);

        v0 = v_cnt; e0 = e_cnt;
        send_bits(32'hABC, 12, 1'b0, 1'b1);
        check("long_err",   32'(e_cnt - e0), 32'd1);
        check("long_valid", 32'(v_cnt - v0), 32'd0);
        check("long_word",  32'(word_out), 32'h2A5);

        v0 = v_cnt; e0 = e_cnt;
        send_bits(32'h155, 10, 1'b0, 1'b1);
        check("f155_valid", 32'(v_cnt - v0), 32'd1);
        check("f155_word",  32'(word_out), 32'h155);
        check("f155_cnt",   32'(frame_cnt_out), 32'd2);

        v0 = v_cnt; e0 = e_cnt;
        send_bits(32'h15, 5, 1'b0, 1'b0);
        check("to_early", 32'(e_cnt - e0), 32'd0);
        waited = 0;
        while (e_cnt == e0 && waited < T + 50) begin
            tick(1);
            waited++;
        end
        tot = waited + 27;
        check("to_err",   32'(e_cnt - e0), 32'd1);
        check("to_lat",   32'(tot >= T + 2 && tot <= T + 8), 32'd1);
        check("to_valid", 32'(v_cnt - v0), 32'd0);

        v0 = v_cnt; e0 = e_cnt;
        tick(5);
        load_in = 1'b1;
        tick(4);
        load_in = 1'b0;
        tick(20);
        check("lone_err",   32'(e_cnt - e0), 32'd0);
        check("lone_valid", 32'(v_cnt - v0), 32'd0);
        check("lone_cnt",   32'(frame_cnt_out), 32'd2);

        v0 = v_cnt; e0 = e_cnt;
        send_bits(32'h3FF, 10, 1'b1, 1'b1);
        check("sim_valid", 32'(v_cnt - v0), 32'd1);
        check("sim_err",   32'(e_cnt - e0), 32'd0);
        check("sim_word",  32'(word_out), 32'h3FF);
        check("sim_cnt",   32'(frame_cnt_out), 32'd3);

        v0 = v_cnt; e0 = e_cnt;
        send_bits(32'h2A, 6, 1'b0, 1'b0);
        rst = 1'b1;
        tick(2);
        check("mid_rst_word", 32'(word_out), 32'h0);
        check("mid_rst_cnt",  32'(frame_cnt_out), 32'd0);
        rst = 1'b0;
        tick(5);
        send_bits(32'h001, 10, 1'b0, 1'b1);
        check("post_word",  32'(word_out), 32'h001);
        check("post_cnt",   32'(frame_cnt_out), 32'd1);
        check("post_err",   32'(e_cnt - e0), 32'd0);
        check("post_valid", 32'(v_cnt - v0), 32'd1);

        check("no_overlap", 32'(ovl), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
